// File: rtl/rib_xbar.sv
// Multi-master / multi-slave bus crossbar: one grant at a time, slave chosen by addr[31:28].
// Routing is combinational from the registered grant, so a slave ack completes the master in the same cycle.
module rib_xbar #(
  parameter int NM       = 3,
  parameter int NS       = 3,
  parameter int DW       = 32,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 255,
  parameter int DEF_M    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM*32-1:0] m_addr_i,
  input  logic [NM*DW-1:0] m_data_i,
  input  logic [NM-1:0]    m_req_i,
  input  logic [NM-1:0]    m_we_i,
  output logic [NM*DW-1:0] m_data_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [NS*32-1:0] s_addr_o,
  output logic [NS*DW-1:0] s_data_o,
  output logic [NS-1:0]    s_req_o,
  output logic [NS-1:0]    s_we_o,
  input  logic [NS*DW-1:0] s_data_i,
  input  logic [NS-1:0]    s_ack_i,
  output logic             hold_flag_o,
  output logic [2:0]       grant_o
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state_reg, state_next;
  logic [2:0]    grant_reg;
  logic [2:0]    rr_ptr_reg;
  logic [TW-1:0] tmo_reg;

  logic [31:0]   m_addr  [NM];
  logic [DW-1:0] m_wdata [NM];
  logic [DW-1:0] s_rdata [NS];
  logic [NM-1:0] nondef_mask;

  for (genvar gi = 0; gi < NM; gi++) begin : g_master
    assign m_addr[gi]      = m_addr_i[gi*32 +: 32];
    assign m_wdata[gi]     = m_data_i[gi*DW +: DW];
    assign nondef_mask[gi] = (gi != DEF_M);
  end

  for (genvar gi = 0; gi < NS; gi++) begin : g_slave
    assign s_rdata[gi] = s_data_i[gi*DW +: DW];
  end

  // Signals of the currently granted master
  logic          g_req, g_we;
  logic [31:0]   g_addr;
  logic [DW-1:0] g_data;

  always_comb begin
    g_req  = 1'b0;
    g_we   = 1'b0;
    g_addr = '0;
    g_data = '0;
    for (int i = 0; i < NM; i++) begin
      if (grant_reg == 3'(i)) begin
        g_req  = m_req_i[i];
        g_we   = m_we_i[i];
        g_addr = m_addr[i];
        g_data = m_wdata[i];
      end
    end
  end

  logic [3:0]    sel;
  logic          hit;
  logic          s_ack_sel;
  logic [DW-1:0] s_rdata_sel;

  assign sel = g_addr[31:28];
  assign hit = ({28'd0, sel} < 32'(NS));

  always_comb begin
    s_ack_sel   = 1'b0;
    s_rdata_sel = '0;
    for (int j = 0; j < NS; j++) begin
      if (sel == 4'(j)) begin
        s_ack_sel   = s_ack_i[j];
        s_rdata_sel = s_rdata[j];
      end
    end
  end

  logic active_req, route, ack_hit, tmo_fire, err, complete;

  assign active_req = (state_reg == ACTIVE) && g_req;
  assign route      = active_req && hit;
  assign ack_hit    = route && s_ack_sel;
  // An ack arriving in the timeout cycle still wins over the error.
  assign tmo_fire   = (TIMEOUT != 0) && route && !s_ack_sel && (tmo_reg == TW'(TIMEOUT));
  assign err        = active_req && (!hit || tmo_fire);
  assign complete   = ack_hit || err;

  // Arbitration: fixed picks lowest index; round-robin searches upward from rr_ptr_reg.
  logic [2:0] winner;
  logic       found;

  always_comb begin
    winner = 3'(DEF_M);
    found  = 1'b0;
    if (ARB_MODE == 0) begin
      for (int i = NM - 1; i >= 0; i--) begin
        if (m_req_i[i]) winner = 3'(i);
      end
    end else begin
      for (int off = 0; off < NM; off++) begin
        for (int i = 0; i < NM; i++) begin
          if (!found && m_req_i[i] &&
              (((int'(rr_ptr_reg) + off >= NM) ? int'(rr_ptr_reg) + off - NM
                                                : int'(rr_ptr_reg) + off) == i)) begin
            winner = 3'(i);
            found  = 1'b1;
          end
        end
      end
    end
  end

  logic [2:0] rr_next;
  assign rr_next = (winner == 3'(NM - 1)) ? 3'd0 : winner + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      grant_reg  <= 3'(DEF_M);
      rr_ptr_reg <= 3'd0;
      tmo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE) begin
        if (|m_req_i) begin
          grant_reg  <= winner;
          rr_ptr_reg <= rr_next;
          tmo_reg    <= '0;
        end else begin
          grant_reg <= 3'(DEF_M);
        end
      end else begin
        tmo_reg <= tmo_reg + TW'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|m_req_i) state_next = ACTIVE;
      ACTIVE:  if (!g_req || complete) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced to zero while rst is high so a reset drops s_req_o in the same cycle.
  always_comb begin
    m_data_o    = '0;
    m_ack_o     = '0;
    m_err_o     = '0;
    s_addr_o    = '0;
    s_data_o    = '0;
    s_req_o     = '0;
    s_we_o      = '0;
    hold_flag_o = 1'b0;
    grant_o     = 3'd0;
    if (!rst) begin
      grant_o     = grant_reg;
      hold_flag_o = (|(m_req_i & nondef_mask)) ||
                    ((state_reg == ACTIVE) && (grant_reg != 3'(DEF_M)));
      for (int i = 0; i < NM; i++) begin
        if (active_req && grant_reg == 3'(i)) begin
          m_ack_o[i]           = complete;
          m_err_o[i]           = err;
          m_data_o[i*DW +: DW] = (hit && !tmo_fire) ? s_rdata_sel : '0;
        end
      end
      for (int j = 0; j < NS; j++) begin
        if (route && sel == 4'(j)) begin
          s_req_o[j]           = !tmo_fire;
          s_we_o[j]            = g_we;
          s_addr_o[j*32 +: 32] = {4'h0, g_addr[27:0]};
          s_data_o[j*DW +: DW] = g_data;
        end
      end
    end
  end

endmodule

// File: doc/rib_xbar.md
RIB_XBAR -- requirements
Module: rib_xbar

Interface
REQ-001 SHALL have parameter NM, default 3: number of masters (1..8).
REQ-002 SHALL have parameter NS, default 3: number of slaves (1..16); slave index = addr[31:28].
REQ-003 SHALL have parameter DW, default 32: data width.
REQ-004 SHALL have parameter ARB_MODE, default 0: 0 = fixed priority (lower index wins), 1 = round-robin.
REQ-005 SHALL have parameter TIMEOUT, default 255: cycles in ACTIVE before error completion; 0 disables.
REQ-006 SHALL have parameter DEF_M, default 1: master granted at reset/idle; its requests do not raise hold.
REQ-007 clk  input  1  clock; all state on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 m_addr_i  input  NM*32  master addresses, master k at [k*32 +: 32].
REQ-010 m_data_i  input  NM*DW  master write data.
REQ-011 m_req_i / m_we_i  input  NM each  request / write enable per master.
REQ-012 m_data_o  output  NM*DW  read data; m_ack_o, m_err_o  output  NM each  completion / error.
REQ-013 s_addr_o  output  NS*32; s_data_o  output  NS*DW; s_req_o, s_we_o  output  NS each.
REQ-014 s_data_i  input  NS*DW; s_ack_i  input  NS  slave read data / completion.
REQ-015 hold_flag_o  output  1  pipeline hold to core; grant_o  output  3  currently granted master index.

Function
REQ-016 SHALL implement FSM IDLE/ACTIVE; grant register holds master index, routing is combinational from registered grant.
REQ-017 IDLE: if any m_req_i set, SHALL select winner per ARB_MODE, load grant, enter ACTIVE next cycle; else stay IDLE with grant = DEF_M.
REQ-018 Round-robin: search starts at rr_ptr, wraps from NM-1 to 0; rr_ptr <= winner+1 (mod NM) on each grant.
REQ-019 ACTIVE, decode hit (sel < NS): s_req_o[sel], s_we_o, s_data_o driven from granted master; s_addr_o = {4'h0, addr[27:0]}; m_ack_o/m_data_o = s_ack_i[sel]/s_data_i[sel] same cycle (zero added latency).
REQ-020 Slave ack with granted req high SHALL return FSM to IDLE next cycle; a new grant costs one IDLE cycle.
REQ-021 Decode miss (sel >= NS): SHALL assert m_ack_o and m_err_o one cycle, data 0, no slave req, then IDLE.
REQ-022 Timeout: counter clears on ACTIVE entry, increments per ACTIVE cycle; at count == TIMEOUT with no ack, SHALL pulse m_ack_o+m_err_o, drop s_req_o that cycle, go IDLE.
REQ-023 Granted master dropping m_req_i in ACTIVE before ack SHALL abort to IDLE next cycle, no ack, no err.
REQ-024 Ungranted masters SHALL see m_ack_o=0, m_err_o=0, m_data_o=0; unselected slaves see req/we/addr/data = 0.
REQ-025 hold_flag_o SHALL be 1 when any m_req_i[k], k != DEF_M, is set, or FSM is ACTIVE with grant != DEF_M; else 0.
REQ-026 Simultaneous requests: exactly one master granted; losers remain pending, hold_flag_o stays 1.
REQ-027 Slave ack while req not asserted or slave unselected SHALL be ignored.

Reset
REQ-028 On rst: FSM=IDLE, grant=DEF_M, rr_ptr=0, timeout counter=0.
REQ-029 During rst all outputs SHALL be 0; reset mid-transaction SHALL drop s_req_o same cycle without ack.

Verification
REQ-030 NM=3,NS=3, m0 reads 0x1000_0010, s1 acks in 2 cycles data 0xA5A5_A5A5 -> s1_addr_o=0x0000_0010, m0 ack+data 0xA5A5_A5A5, hold_flag_o=1 until IDLE.
REQ-031 ARB_MODE=0, m0,m1,m2 req same cycle, immediate acks -> grant order 0,0,... while m0 holds req; m2 starved (expected).
REQ-032 ARB_MODE=1, all three req continuously, 1-cycle acks -> grant sequence 0,1,2,0,1,2.
REQ-033 m2 addr 0x5000_0000 (NS=3) -> m_ack_o[2]=1, m_err_o[2]=1, all s_req_o=0.
REQ-034 TIMEOUT=4, slave never acks -> err ack exactly 4 ACTIVE cycles after grant, FSM IDLE next cycle.
REQ-035 rst asserted during ACTIVE -> s_req_o=0 same cycle, grant_o=DEF_M after release.
